// File: rtl/clk_gate_ctrl.sv
// -----------------------------------------------------------------------------
// clk_gate_ctrl
//
// Multi-channel clock-gating controller. Every channel has its own small FSM
// (RUN -> HOLD -> GATED -> WAKE -> RUN) and its own integrated clock gate
// (low-transparent enable latch followed by an AND with the root clock).
//
// A channel is considered active while req_i or force_on_i is high. After
// IDLE_CYCLES of inactivity the channel clock is stopped; when activity
// returns the clock is re-enabled immediately and ack_o follows after
// WAKE_CYCLES clocked cycles.
//
// Ports
//   clk_i       in   1       free-running root clock, the only clock here
//   rst_i       in   1       synchronous reset, active-high
//   te_i        in   1       test enable, opens every clock gate
//   req_i       in   NUM_CH  per-channel clock request (level)
//   force_on_i  in   NUM_CH  software override, keeps the channel running
//   gclk_o      out  NUM_CH  gated clock per channel
//   ack_o       out  NUM_CH  channel clock running and stable
//   gated_o     out  NUM_CH  channel is in GATED
// -----------------------------------------------------------------------------
module clk_gate_ctrl #(
  parameter int NUM_CH      = 4,
  parameter int IDLE_CYCLES = 8,
  parameter int WAKE_CYCLES = 2,
  parameter bit RESET_RUN   = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              te_i,
  input  logic [NUM_CH-1:0] req_i,
  input  logic [NUM_CH-1:0] force_on_i,
  output logic [NUM_CH-1:0] gclk_o,
  output logic [NUM_CH-1:0] ack_o,
  output logic [NUM_CH-1:0] gated_o
);

  // Counter only has to hold the larger of the two delays minus one; keep at
  // least one bit so both delays may be zero.
  localparam int MAX_CYC = (IDLE_CYCLES > WAKE_CYCLES) ? IDLE_CYCLES : WAKE_CYCLES;
  localparam int CW      = (MAX_CYC > 0) ? $clog2(MAX_CYC + 1) : 1;

  localparam logic [CW-1:0] IDLE_LOAD = CW'((IDLE_CYCLES > 0) ? (IDLE_CYCLES - 1) : 0);
  localparam logic [CW-1:0] WAKE_LOAD = CW'((WAKE_CYCLES > 0) ? (WAKE_CYCLES - 1) : 0);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HOLD  = 2'd1,
    ST_GATED = 2'd2,
    ST_WAKE  = 2'd3
  } state_t;

  localparam state_t RESET_STATE = RESET_RUN ? ST_RUN : ST_GATED;

  // Set on every edge that samples rst_i high and cleared on the first edge
  // after release. While set, the FSMs stay parked in their reset state, the
  // status outputs read zero and the clock gates stay open. This makes the
  // first edge after release land the channel exactly in its reset state.
  logic r_in_rst;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_in_rst <= 1'b1;
    end else begin
      r_in_rst <= 1'b0;
    end
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch

    state_t          r_state;
    state_t          w_state_next;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_next;
    logic            w_act;
    logic            w_en;
    logic            r_en_latch;

    assign w_act = req_i[gi] | force_on_i[gi];

    // State register. Reset aborts any HOLD/WAKE sequence and clears cnt.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        r_state <= RESET_STATE;
        r_cnt   <= '0;
      end else begin
        r_state <= w_state_next;
        r_cnt   <= w_cnt_next;
      end
    end

    // Next-state logic.
    always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      if (!r_in_rst) begin
        unique case (r_state)
          ST_RUN: begin
            if (!w_act) begin
              if (IDLE_CYCLES == 0) begin
                w_state_next = ST_GATED;
              end else begin
                w_state_next = ST_HOLD;
                w_cnt_next   = IDLE_LOAD;
              end
            end
          end

          ST_HOLD: begin
            if (w_act) begin
              w_state_next = ST_RUN;
            end else if (r_cnt == '0) begin
              w_state_next = ST_GATED;
            end else begin
              w_cnt_next = r_cnt - 1'b1;
            end
          end

          ST_GATED: begin
            if (w_act) begin
              if (WAKE_CYCLES == 0) begin
                w_state_next = ST_RUN;
              end else begin
                w_state_next = ST_WAKE;
                w_cnt_next   = WAKE_LOAD;
              end
            end
          end

          ST_WAKE: begin
            // Activity is deliberately ignored here: a wake-up always runs
            // to completion and RUN then decides what happens next.
            if (r_cnt == '0) begin
              w_state_next = ST_RUN;
            end else begin
              w_cnt_next = r_cnt - 1'b1;
            end
          end

          default: begin
            w_state_next = RESET_STATE;
            w_cnt_next   = '0;
          end
        endcase
      end
    end

    // Gate enable. rst_i is used directly so the gate opens in the very
    // cycle reset is raised, letting downstream synchronous resets see the
    // next edge.
    assign w_en = (r_state != ST_GATED) | rst_i | r_in_rst | te_i;

    // Enable latch is transparent only while clk_i is low, so the AND below
    // can never produce a truncated or glitched high phase.
    always_latch begin
      if (!clk_i) begin
        r_en_latch <= w_en;
      end
    end

    assign gclk_o[gi]  = clk_i & r_en_latch;

    // Status decoded purely from registers.
    assign ack_o[gi]   = ((r_state == ST_RUN) | (r_state == ST_HOLD)) & ~r_in_rst;
    assign gated_o[gi] = (r_state == ST_GATED) & ~r_in_rst;

  end : g_ch

endmodule : clk_gate_ctrl

// File: tb/tb_clk_gate_ctrl.sv
// -----------------------------------------------------------------------------
// tb_clk_gate_ctrl
//
// Scoreboard bench for clk_gate_ctrl (NUM_CH=4, IDLE=8, WAKE=2, RESET_RUN=1).
// The driver applies inputs on the falling edge, advances a behavioural model
// of the channels and queues the expected gclk/ack/gated values for the next
// rising edge. The monitor pops them after that edge and compares, and also
// checks that every gated clock is low during clk's low phase.
// -----------------------------------------------------------------------------
module tb_clk_gate_ctrl;

  localparam int NUM_CH = 4;
  localparam int IDLE   = 8;
  localparam int WAKE   = 2;

  // Model channel modes
  localparam int M_ON    = 0;  // RUN or HOLD: clock running, ack high
  localparam int M_GATED = 2;
  localparam int M_WAKE  = 3;

  logic              clk;
  logic              rst_i;
  logic              te_i;
  logic [NUM_CH-1:0] req_i;
  logic [NUM_CH-1:0] force_on_i;
  logic [NUM_CH-1:0] gclk_o;
  logic [NUM_CH-1:0] ack_o;
  logic [NUM_CH-1:0] gated_o;

  clk_gate_ctrl #(
    .NUM_CH      (NUM_CH),
    .IDLE_CYCLES (IDLE),
    .WAKE_CYCLES (WAKE),
    .RESET_RUN   (1'b1)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .te_i       (te_i),
    .req_i      (req_i),
    .force_on_i (force_on_i),
    .gclk_o     (gclk_o),
    .ack_o      (ack_o),
    .gated_o    (gated_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [NUM_CH-1:0] gclk;
    logic [NUM_CH-1:0] ack;
    logic [NUM_CH-1:0] gated;
  } exp_t;

  exp_t sb_q[$];

  int n_vec = 0;
  int n_err = 0;
  bit started = 1'b0;

  // Behavioural model state
  int m_mode [NUM_CH];
  int m_idle [NUM_CH];  // consecutive inactive edges seen while running
  int m_wake [NUM_CH];  // edges spent in wake-up
  bit m_in_rst;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  // Apply one cycle of stimulus and queue what the next rising edge must show.
  task automatic drive(input bit rst, input bit te,
                       input logic [NUM_CH-1:0] req, input logic [NUM_CH-1:0] frc);
    exp_t e;
    bit   act;
    @(negedge clk);
    rst_i      = rst;
    te_i       = te;
    req_i      = req;
    force_on_i = frc;
    for (int c = 0; c < NUM_CH; c++) begin
      // Gate value latched during this low phase, seen at the next edge.
      e.gclk[c] = (m_mode[c] != M_GATED) || rst || m_in_rst || te;
    end
    if (rst) begin
      m_in_rst = 1'b1;
      for (int c = 0; c < NUM_CH; c++) begin
        m_mode[c] = M_ON;
        m_idle[c] = 0;
        m_wake[c] = 0;
      end
    end else if (m_in_rst) begin
      m_in_rst = 1'b0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        act = req[c] | frc[c];
        case (m_mode[c])
          M_ON: begin
            if (act) begin
              m_idle[c] = 0;
            end else begin
              m_idle[c]++;
              if (m_idle[c] == IDLE + 1) m_mode[c] = M_GATED;
            end
          end
          M_GATED: begin
            if (act) begin
              m_mode[c] = M_WAKE;
              m_wake[c] = 0;
            end
          end
          default: begin
            m_wake[c]++;
            if (m_wake[c] == WAKE) begin
              m_mode[c] = M_ON;
              m_idle[c] = 0;
            end
          end
        endcase
      end
    end
    for (int c = 0; c < NUM_CH; c++) begin
      e.ack[c]   = (m_mode[c] == M_ON) && !m_in_rst;
      e.gated[c] = (m_mode[c] == M_GATED) && !m_in_rst;
    end
    sb_q.push_back(e);
  endtask

  task automatic run(input int n, input bit te,
                     input logic [NUM_CH-1:0] req, input logic [NUM_CH-1:0] frc);
    for (int i = 0; i < n; i++) drive(1'b0, te, req, frc);
  endtask

  // Monitor: compare right after the rising edge and again late in the high
  // phase, so a shortened gated pulse is caught too.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("ack",      32'(ack_o),   32'(e.ack));
      check("gated",    32'(gated_o), 32'(e.gated));
      check("gclk_hi",  32'(gclk_o),  32'(e.gclk));
      #3;
      check("gclk_end", 32'(gclk_o),  32'(e.gclk));
    end
  end

  always @(negedge clk) begin
    #1;
    if (started) check("gclk_lo", 32'(gclk_o), 32'd0);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NUM_CH-1:0] r_req;
    logic [NUM_CH-1:0] r_frc;
    bit                r_te;
    rst_i      = 1'b1;
    te_i       = 1'b0;
    req_i      = '1;
    force_on_i = '0;
    m_in_rst   = 1'b1;
    for (int c = 0; c < NUM_CH; c++) begin
      m_mode[c] = M_ON;
      m_idle[c] = 0;
      m_wake[c] = 0;
    end
    started = 1'b1;

    // Reset with all requests held, then steady running
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 4'hF, 4'h0);
    run(8, 1'b0, 4'hF, 4'h0);

    // Idle hold-off on ch0, then wake it
    run(20, 1'b0, 4'hE, 4'h0);
    run(10, 1'b0, 4'hF, 4'h0);

    // Short gap on ch2 must not gate it
    run(5, 1'b0, 4'hB, 4'h0);
    run(10, 1'b0, 4'hF, 4'h0);

    // force_on keeps ch3 alive while the others gate
    run(100, 1'b0, 4'h0, 4'h8);

    // All gated, then test enable opens every gate
    run(15, 1'b0, 4'h0, 4'h0);
    run(10, 1'b1, 4'h0, 4'h0);
    run(3, 1'b0, 4'h0, 4'h0);

    // One-cycle request on ch1: wake-up completes anyway, then it re-gates
    run(1, 1'b0, 4'h2, 4'h0);
    run(14, 1'b0, 4'h0, 4'h0);

    // Reset in the middle of a wake-up
    run(1, 1'b0, 4'hF, 4'h0);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 4'hF, 4'h0);
    run(10, 1'b0, 4'hF, 4'h0);

    // Reset mid-hold with RESET_RUN state then idle
    run(4, 1'b0, 4'h0, 4'h0);
    drive(1'b1, 1'b0, 4'h0, 4'h0);
    run(15, 1'b0, 4'h0, 4'h0);

    // Random segments
    for (int s = 0; s < 40; s++) begin
      r_req = NUM_CH'($urandom_range(0, 15));
      r_frc = NUM_CH'($urandom_range(0, 15)) & NUM_CH'($urandom_range(0, 15));
      r_te  = ($urandom_range(0, 9) == 0);
      run(int'($urandom_range(1, 12)), r_te, r_req, r_frc);
    end

    @(posedge clk);
    #6;
    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_clk_gate_ctrl
